if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage feeding the CPU's decode stage: owns the PC register,
//  next-PC selection (PC+4 / branch / jump), and the IF/ID pipeline register.
//  Honours stall requests from the hazard detection unit and flushes from the
//  branch/jump logic. Drives the instruction memory address; captures its
//  combinational read data into IF/ID.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction injected into IF/ID on flush, reset or idle
// PORTS
//  clk_i            in   1   clock
//  rst_i            in   1   reset, synchronous, active-high
//  start_i          in   1   level run enable; low = hold PC, emit bubbles
//  pc_write_i       in   1   from hazard unit; 0 = hold PC
//  ifid_write_i     in   1   from hazard unit; 0 = hold IF/ID contents
//  flush_i          in   1   overwrite IF/ID with NOP on next edge
//  branch_taken_i   in   1   select branch_target_i as next PC
//  branch_target_i  in   32  branch target address
//  jump_i           in   1   select jump_target_i as next PC
//  jump_target_i    in   32  jump target address
//  imem_addr_o      out  32  instruction memory address (= current PC)
//  imem_instr_i     in   32  instruction word for imem_addr_o, same cycle
//  ifid_pc4_o       out  32  registered PC+4 of the instruction in IF/ID
//  ifid_instr_o     out  32  registered instruction
//  ifid_valid_o     out  1   1 = ifid_instr_o is a real fetched instruction
//  fetch_count_o    out  32  count of instructions loaded into IF/ID with valid=1
// BEHAVIOUR
//  - Reset (all sync on clk_i rising): pc<=RESET_PC, ifid_pc4_o<=0,
//    ifid_instr_o<=NOP_INSTR, ifid_valid_o<=0, fetch_count_o<=0, state<=IDLE.
//  - FSM: IDLE -> RUN when start_i sampled 1; RUN -> IDLE when start_i sampled 0.
//    rst_i wins over every other input, in both states.
//  - IDLE: PC holds. IF/ID loads NOP_INSTR, valid 0, pc4 0. Counter holds.
//  - RUN, PC update, only when pc_write_i=1. Priority: jump_i > branch_taken_i > PC+4.
//    Targets are loaded with bits [1:0] forced to 0.
//    PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
//    pc_write_i=0: PC holds and redirect inputs are ignored. The control path
//    must hold a redirect until pc_write_i=1.
//  - RUN, IF/ID update. Priority: flush_i > ifid_write_i.
//      flush_i=1: instr<=NOP_INSTR, valid<=0, pc4<=0, even when ifid_write_i=0.
//      ifid_write_i=1: instr<=imem_instr_i, pc4<=pc+4, valid<=1, count+=1 (wraps).
//      ifid_write_i=0: all IF/ID outputs and the counter hold.
//  - Latency: instruction at PC p is visible on ifid_instr_o 1 cycle after p
//    appears on imem_addr_o.
//  - imem_addr_o equals the PC register directly; no combinational path from redirect inputs.
//  - Redirect with flush_i in the same cycle: next PC = target and IF/ID = NOP,
//    so one bubble per taken branch or jump.
//  - start_i falling mid-stream: the in-flight IF/ID word is replaced by NOP on the next edge.
// STRUCTURE
//  - Shared package cpu_pkg: NOP_INSTR, RESET_PC, if_state_t {IDLE, RUN}, and
//    INSTR_W=32 / ADDR_W=32 constants.
//  - Sub-module pc_sel: combinational next-PC priority mux with target alignment.
//  - Top level holds PC register, IF/ID registers, FSM and counter.
// TESTING
//  1 Reset, start_i=1, stalls low, 4 cycles -> imem_addr_o 0,4,8,C.
//    ifid_instr_o tracks memory one cycle later; fetch_count_o=3 after 4th edge.
//  2 pc_write_i=0, ifid_write_i=0 for 2 cycles at PC=8 -> PC stays 8; IF/ID and
//    count hold; fetch resumes at 8 on release.
//  3 branch_taken_i=1, target 32'h40, plus flush_i=1 -> next PC 32'h40.
//    IF/ID = NOP, valid 0; next edge loads the instruction at 32'h40.
//  4 jump_i=1 (target 32'h100) and branch_taken_i=1 (target 32'h40) together
//    -> PC 32'h100. Target 32'h103 -> PC 32'h100.
//  5 PC=32'hFFFF_FFFC, no redirect -> PC wraps to 0; ifid_pc4_o=0.
//  6 rst_i=1 mid-run with flush_i=1 and jump_i=1 -> RESET_PC, NOP, valid 0,
//    count 0, state IDLE; no fetch until start_i is resampled high.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset/bubble constants and fetch FSM states.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } if_state_t;

    // Instruction fetches are word aligned, so the low two address bits are dropped.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sel.sv
// Next-PC selection: jump beats branch beats sequential PC+4; targets are word aligned.
module pc_sel
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + ADDR_W'(4);
        if (jump) begin
            next_pc = align_word(jump_target);
        end else if (branch_taken) begin
            next_pc = align_word(branch_target);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, run/idle control, fetch counter and IF/ID register.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               pc_write_i,
    input  logic               ifid_write_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               jump_i,
    input  logic [ADDR_W-1:0]  jump_target_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic [ADDR_W-1:0]  ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o,
    output logic [31:0]        fetch_count_o
);

    if_state_t          state_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  ifid_pc4_reg;
    logic [INSTR_W-1:0] ifid_instr_reg;
    logic               ifid_valid_reg;
    logic [31:0]        fetch_count_reg;

    pc_sel u_pc_sel (
        .pc            (pc_reg),
        .jump          (jump_i),
        .jump_target   (jump_target_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .next_pc       (pc_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            ifid_pc4_reg    <= '0;
            ifid_instr_reg  <= NOP_INSTR;
            ifid_valid_reg  <= 1'b0;
            fetch_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The first edge with start high only arms the FSM; fetching begins next edge.
                    ifid_pc4_reg   <= '0;
                    ifid_instr_reg <= NOP_INSTR;
                    ifid_valid_reg <= 1'b0;
                    if (start_i) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!start_i) begin
                        // Dropping start discards the in-flight word and freezes the PC.
                        state_reg      <= IDLE;
                        ifid_pc4_reg   <= '0;
                        ifid_instr_reg <= NOP_INSTR;
                        ifid_valid_reg <= 1'b0;
                    end else begin
                        if (pc_write_i) begin
                            pc_reg <= pc_next;
                        end
                        if (flush_i) begin
                            ifid_pc4_reg   <= '0;
                            ifid_instr_reg <= NOP_INSTR;
                            ifid_valid_reg <= 1'b0;
                        end else if (ifid_write_i) begin
                            ifid_pc4_reg    <= pc_reg + ADDR_W'(4);
                            ifid_instr_reg  <= imem_instr_i;
                            ifid_valid_reg  <= 1'b1;
                            fetch_count_reg <= fetch_count_reg + 32'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign imem_addr_o   = pc_reg;
    assign ifid_pc4_o    = ifid_pc4_reg;
    assign ifid_instr_o  = ifid_instr_reg;
    assign ifid_valid_o  = ifid_valid_reg;
    assign fetch_count_o = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic against a behavioural fetch model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pc_write;
    logic        ifid_write;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_cnt;
    logic        m_run;

    if_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .pc_write_i      (pc_write),
        .ifid_write_i    (ifid_write),
        .flush_i         (flush),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .imem_addr_o     (imem_addr),
        .imem_instr_i    (imem_instr),
        .ifid_pc4_o      (ifid_pc4),
        .ifid_instr_o    (ifid_instr),
        .ifid_valid_o    (ifid_valid),
        .fetch_count_o   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a scrambled function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge of the reference behaviour, using the inputs held across that edge.
    task automatic model_edge();
        logic [31:0] nxt;
        if (rst) begin
            m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_cnt = 32'h0; m_run = 1'b0;
        end else if (!(m_run && start)) begin
            m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_run = start;
        end else begin
            nxt = m_pc;
            if (pc_write) begin
                if (jump)              nxt = jump_target - (jump_target % 4);
                else if (branch_taken) nxt = branch_target - (branch_target % 4);
                else                   nxt = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            end
            if (flush) begin
                m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            end else if (ifid_write) begin
                m_instr = mem_word(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
            m_pc = nxt;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".addr"},  imem_addr,   m_pc);
        chk({tag, ".pc4"},   ifid_pc4,    m_pc4);
        chk({tag, ".instr"}, ifid_instr,  m_instr);
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
        chk({tag, ".count"}, fetch_count, m_cnt);
    endtask

    task automatic quiet();
        pc_write = 1'b1; ifid_write = 1'b1; flush = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        quiet();
        m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_cnt = 32'h0; m_run = 1'b0;

        // Reset state
        step("reset");
        step("reset");
        chk("reset_addr_const", imem_addr, 32'h0);
        chk("reset_valid_const", 32'(ifid_valid), 32'h0);

        // Sequential fetch 0,4,8,C
        rst = 1'b0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("seq");
            chk("seq_addr_const", imem_addr, 32'(4 * i));
        end
        chk("seq_count_const", fetch_count, 32'd3);

        // Return to 8, then stall PC and IF/ID for two cycles
        jump = 1'b1; jump_target = 32'h8; flush = 1'b1;
        step("goto8");
        quiet(); pc_write = 1'b0; ifid_write = 1'b0;
        jump = 1'b1; jump_target = 32'h200;  // ignored while stalled
        step("stall");
        step("stall");
        chk("stall_addr_const", imem_addr, 32'h8);
        quiet();
        step("release");
        chk("release_instr_const", ifid_instr, mem_word(32'h8));
        chk("release_addr_const", imem_addr, 32'hC);

        // Taken branch with flush: one bubble then the target instruction
        branch_taken = 1'b1; branch_target = 32'h40; flush = 1'b1;
        step("branch");
        chk("branch_addr_const", imem_addr, 32'h40);
        chk("branch_bubble_const", 32'(ifid_valid), 32'h0);
        quiet();
        step("after_branch");
        chk("after_branch_instr", ifid_instr, mem_word(32'h40));
        chk("after_branch_pc4", ifid_pc4, 32'h44);

        // Jump beats branch; unaligned target is aligned down
        jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h40;
        step("jump_prio");
        chk("jump_prio_const", imem_addr, 32'h100);
        quiet(); jump = 1'b1; jump_target = 32'h103;
        step("jump_align");
        chk("jump_align_const", imem_addr, 32'h100);

        // Wrap of PC+4 at the top of the address space
        quiet(); jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step("to_top");
        quiet();
        step("wrap");
        chk("wrap_addr_const", imem_addr, 32'h0);
        chk("wrap_pc4_const", ifid_pc4, 32'h0);

        // start dropping mid-stream bubbles the in-flight word
        start = 1'b0;
        step("start_low");
        chk("start_low_valid", 32'(ifid_valid), 32'h0);
        start = 1'b1;
        step("rearm");
        step("resume");

        // Reset wins over flush and jump
        rst = 1'b1; flush = 1'b1; jump = 1'b1; jump_target = 32'h300;
        step("midrst");
        chk("midrst_count_const", fetch_count, 32'h0);
        quiet(); rst = 1'b0; start = 1'b0;
        step("post_rst_idle");
        step("post_rst_idle");
        start = 1'b1;
        step("post_rst_arm");
        chk("post_rst_arm_valid", 32'(ifid_valid), 32'h0);
        step("post_rst_fetch");
        chk("post_rst_fetch_addr", imem_addr, 32'h4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            start         = ($urandom_range(0, 15) != 0);
            pc_write      = ($urandom_range(0, 3) != 0);
            ifid_write    = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_target = $urandom;
            jump_target   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
